// File: rtl/ysyx_23060075_mem_ctrl.sv
// AXI4-Lite master bridging the core's single-request memory port onto all five AXI channels.
// Optional hang watchdog is enabled by defining YSYX_23060075_MEM_CTRL_TIMEOUT_EN.
module ysyx_23060075_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
    input  logic                    mem_r_en_i,
    input  logic                    mem_w_en_i,
    input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] mem_wmask_i,
    output logic [DATA_WIDTH-1:0]   mem_rdata_o,
    output logic                    mem_finish_o,
    output logic                    mem_err_o,
    output logic                    mem_busy_o,
    output logic [ADDR_WIDTH-1:0]   axi_araddr_o,
    output logic                    axi_arvalid_o,
    input  logic                    axi_arready_i,
    input  logic [DATA_WIDTH-1:0]   axi_rdata_i,
    input  logic [1:0]              axi_rresp_i,
    input  logic                    axi_rvalid_i,
    output logic                    axi_rready_o,
    output logic [ADDR_WIDTH-1:0]   axi_awaddr_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    output logic [DATA_WIDTH-1:0]   axi_wdata_o,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("DATA_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp} state_e;

    state_e                    state_q;
    logic [ADDR_WIDTH-1:0]     araddr_q, awaddr_q;
    logic [DATA_WIDTH-1:0]     wdata_q, rdata_q;
    logic [DATA_WIDTH/8-1:0]   wstrb_q;
    logic                      arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                      finish_q, err_q, aw_done_q, w_done_q;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;
    logic wdog_hit;

    assign ar_hs  = arvalid_q & axi_arready_i;
    assign r_hs   = rready_q & axi_rvalid_i;
    assign aw_hs  = awvalid_q & axi_awready_i;
    assign w_hs   = wvalid_q & axi_wready_i;
    assign b_hs   = bready_q & axi_bvalid_i;
    // A channel counts as done if it completed earlier or handshakes this cycle.
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

`ifdef YSYX_23060075_MEM_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] wdog_cnt_q;

    // A completing handshake on the expiry edge wins over the abort.
    assign wdog_hit = (state_q != StIdle) && (wdog_cnt_q == CntLast) && !(r_hs || b_hs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q <= '0;
        end else if (state_q == StIdle) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_q + 1'b1;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            araddr_q  <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            finish_q  <= 1'b0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (mem_r_en_i) begin
                        araddr_q  <= mem_addr_i;
                        arvalid_q <= 1'b1;
                        state_q   <= StRaddr;
                    end else if (mem_w_en_i) begin
                        awaddr_q  <= mem_addr_i;
                        wdata_q   <= mem_wdata_i;
                        wstrb_q   <= mem_wmask_i;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        state_q   <= StWreq;
                    end
                end
                StRaddr: begin
                    if (ar_hs) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= StRdata;
                    end
                end
                StRdata: begin
                    if (r_hs) begin
                        rready_q <= 1'b0;
                        rdata_q  <= axi_rdata_i;
                        err_q    <= |axi_rresp_i;
                        finish_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                StWreq: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= StWresp;
                    end
                end
                StWresp: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        err_q    <= |axi_bresp_i;
                        finish_q <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (wdog_hit) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b0;
                awvalid_q <= 1'b0;
                wvalid_q  <= 1'b0;
                bready_q  <= 1'b0;
                finish_q  <= 1'b1;
                err_q     <= 1'b1;
                state_q   <= StIdle;
            end
        end
    end

    assign mem_rdata_o   = rdata_q;
    assign mem_finish_o  = finish_q;
    assign mem_err_o     = err_q;
    assign mem_busy_o    = (state_q != StIdle);
    assign axi_araddr_o  = araddr_q;
    assign axi_arvalid_o = arvalid_q;
    assign axi_rready_o  = rready_q;
    assign axi_awaddr_o  = awaddr_q;
    assign axi_awvalid_o = awvalid_q;
    assign axi_wdata_o   = wdata_q;
    assign axi_wstrb_o   = wstrb_q;
    assign axi_wvalid_o  = wvalid_q;
    assign axi_bready_o  = bready_q;

endmodule
